// File: rtl/traffic_phase_scheduler_if.sv
// Lamp/countdown bundle between the crossroads scheduler and its surroundings.
// The night input exists only when NIGHT_FLASH_EN is defined.
interface traffic_phase_scheduler_if;
    logic       country_req;
`ifdef NIGHT_FLASH_EN
    logic       night;
`endif
    logic [5:0] led;
    logic [7:0] num;
    logic       phase_done;

    modport master (
        output country_req,
`ifdef NIGHT_FLASH_EN
        output night,
`endif
        input  led,
        input  num,
        input  phase_done
    );

    modport slave (
        input  country_req,
`ifdef NIGHT_FLASH_EN
        input  night,
`endif
        output led,
        output num,
        output phase_done
    );
endinterface

// File: rtl/traffic_phase_scheduler.sv
// Main/country crossroads phase sequencer with 1 s tick divider, request latch and BCD countdown.
// Optional night flashing mode is enabled by defining NIGHT_FLASH_EN.
module traffic_phase_scheduler #(
    parameter int unsigned DIV_COEFF = 50_000_000,
    parameter int unsigned T_MG_MIN  = 25,
    parameter int unsigned T_Y       = 5,
    parameter int unsigned T_CG      = 20
) (
    input  logic                         clk,
    input  logic                         rst,
    traffic_phase_scheduler_if.slave     bus
);

    localparam int unsigned    DW       = $clog2(DIV_COEFF);
    localparam logic [DW-1:0]  DIV_LAST = DW'(DIV_COEFF - 1);
    localparam logic [6:0]     TMR_MG   = 7'(T_MG_MIN);
    localparam logic [6:0]     TMR_Y    = 7'(T_Y);
    localparam logic [6:0]     TMR_CG   = 7'(T_CG);
    localparam logic [5:0]     LED_MG   = 6'b001100;
    localparam logic [5:0]     LED_MY   = 6'b010100;
    localparam logic [5:0]     LED_CG   = 6'b100001;
    localparam logic [5:0]     LED_CY   = 6'b100010;

    typedef enum logic [2:0] {
        S_MG,
        S_MY,
        S_CG,
        S_CY
`ifdef NIGHT_FLASH_EN
        , S_FLASH
`endif
    } state_t;

    state_t         r_state, w_state_nxt;
    logic [DW-1:0]  r_div_cnt;
    logic [6:0]     r_timer, w_timer_nxt;
    logic           r_req_lat, w_req_nxt;
    logic [5:0]     r_led, w_led_nxt;
    logic           r_phase_done;
    logic           w_tick;
    logic           w_req_any;
    logic           w_illegal;
    logic [3:0]     w_tens;
    logic [3:0]     w_ones;
    logic           r_blink, w_blink_nxt;

    assign w_tick    = (r_div_cnt == DIV_LAST);
    assign w_req_any = r_req_lat | bus.country_req;

    // An illegal state encoding takes the same path as reset.
    always_ff @(posedge clk) begin
        if (rst || w_illegal) begin
            r_state      <= S_MG;
            r_timer      <= TMR_MG;
            r_div_cnt    <= '0;
            r_req_lat    <= 1'b0;
            r_led        <= LED_MG;
            r_phase_done <= 1'b0;
            r_blink      <= 1'b1;
        end else begin
            r_state      <= w_state_nxt;
            r_timer      <= w_timer_nxt;
            r_div_cnt    <= w_tick ? '0 : r_div_cnt + DW'(1);
            r_req_lat    <= w_req_nxt;
            r_led        <= w_led_nxt;
            r_phase_done <= (w_state_nxt != r_state);
            r_blink      <= w_blink_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        w_req_nxt   = w_req_any;
        w_illegal   = 1'b0;
        w_blink_nxt = 1'b1;
        case (r_state)
            S_MG: if (w_tick) begin
                if (r_timer > 7'd1)       w_timer_nxt = r_timer - 7'd1;
                else if (r_timer == 7'd1) w_timer_nxt = '0;
                else if (w_req_any) begin
                    w_state_nxt = S_MY;
                    w_timer_nxt = TMR_Y;
                end
            end
            S_MY: if (w_tick) begin
                if (r_timer > 7'd1) w_timer_nxt = r_timer - 7'd1;
                else begin
                    w_state_nxt = S_CG;
                    w_timer_nxt = TMR_CG;
                end
            end
            S_CG: if (w_tick) begin
                if (r_timer > 7'd1) w_timer_nxt = r_timer - 7'd1;
                else begin
                    w_state_nxt = S_CY;
                    w_timer_nxt = TMR_Y;
                end
            end
            S_CY: if (w_tick) begin
                if (r_timer > 7'd1) w_timer_nxt = r_timer - 7'd1;
                else begin
                    w_state_nxt = S_MG;
                    w_timer_nxt = TMR_MG;
                end
            end
`ifdef NIGHT_FLASH_EN
            S_FLASH: begin
                w_timer_nxt = '0;
                w_blink_nxt = w_tick ? ~r_blink : r_blink;
            end
`endif
            default: w_illegal = 1'b1;
        endcase
        // A request arriving on the CG entry edge is dropped with the latch.
        if (w_state_nxt == S_CG && r_state != S_CG)
            w_req_nxt = 1'b0;
`ifdef NIGHT_FLASH_EN
        if (bus.night) begin
            w_state_nxt = S_FLASH;
            w_timer_nxt = '0;
            w_req_nxt   = 1'b0;
            if (r_state != S_FLASH)
                w_blink_nxt = 1'b1;
        end else if (r_state == S_FLASH) begin
            w_state_nxt = S_MG;
            w_timer_nxt = TMR_MG;
        end
`endif
    end

    always_comb begin
        case (w_state_nxt)
            S_MG:    w_led_nxt = LED_MG;
            S_MY:    w_led_nxt = LED_MY;
            S_CG:    w_led_nxt = LED_CG;
            S_CY:    w_led_nxt = LED_CY;
`ifdef NIGHT_FLASH_EN
            S_FLASH: w_led_nxt = {1'b0, w_blink_nxt, 2'b00, w_blink_nxt, 1'b0};
`endif
            default: w_led_nxt = LED_MG;
        endcase
        w_tens = '0;
        for (int unsigned k = 1; k < 10; k++)
            if (r_timer >= 7'(k * 10))
                w_tens = 4'(k);
        w_ones = 4'(r_timer - 7'(w_tens * 4'd10));
    end

    assign bus.led        = r_led;
    assign bus.num        = {w_tens, w_ones};
    assign bus.phase_done = r_phase_done;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Directed self-checking bench for traffic_phase_scheduler (DIV_COEFF=4, T_MG_MIN=3, T_Y=2, T_CG=4).
// Edge numbers in the stimulus count rising edges since the latest reset release.
module tb_traffic_phase_scheduler;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk  = 0;
    int   n_fail = 0;
    int   cyc    = 0;

    traffic_phase_scheduler_if bus ();

    traffic_phase_scheduler #(
        .DIV_COEFF (4),
        .T_MG_MIN  (3),
        .T_Y       (2),
        .T_CG      (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic go(input int target);
        while (cyc < target) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s @edge %0d: observed %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [5:0] led, input logic [7:0] num,
                           input logic pd);
        chk({tag, ".led"}, {2'b00, bus.led}, {2'b00, led});
        chk({tag, ".num"}, bus.num, num);
        chk({tag, ".pd"},  {7'd0, bus.phase_done}, {7'd0, pd});
    endtask

    initial begin
        bus.country_req = 1'b0;
`ifdef NIGHT_FLASH_EN
        bus.night = 1'b0;
`endif
        @(negedge clk);

        // 1: reset state and idle main green countdown
        do_reset();
        chk_all("rst", 6'b001100, 8'h03, 1'b0);
        go(3);  chk_all("pre_tick1", 6'b001100, 8'h03, 1'b0);
        go(4);  chk_all("tick1", 6'b001100, 8'h02, 1'b0);
        go(8);  chk_all("tick2", 6'b001100, 8'h01, 1'b0);
        go(12); chk_all("tick3", 6'b001100, 8'h00, 1'b0);
        for (int i = 1; i <= 20; i++) begin
            go(12 + 4 * i);
            chk_all("idle_mg", 6'b001100, 8'h00, 1'b0);
        end

        // 2: single-cycle request, then a full cycle of phases
        do_reset();
        go(4);
        bus.country_req = 1'b1;
        go(5);
        bus.country_req = 1'b0;
        go(8);  chk_all("req_t2", 6'b001100, 8'h01, 1'b0);
        go(12); chk_all("req_t3", 6'b001100, 8'h00, 1'b0);
        go(16); chk_all("enter_my", 6'b010100, 8'h02, 1'b1);
        go(17); chk_all("my_pd_drop", 6'b010100, 8'h02, 1'b0);
        go(20); chk_all("my_t1", 6'b010100, 8'h01, 1'b0);
        go(24); chk_all("enter_cg", 6'b100001, 8'h04, 1'b1);
        go(40); chk_all("enter_cy", 6'b100010, 8'h02, 1'b1);
        go(48); chk_all("enter_mg", 6'b001100, 8'h03, 1'b1);
        go(64); chk_all("mg_no_req", 6'b001100, 8'h00, 1'b0);

        // 3: held request, request on CG entry edge dropped, request during CG kept
        do_reset();
        bus.country_req = 1'b1;
        go(15); chk_all("held_mg", 6'b001100, 8'h00, 1'b0);
        go(16); chk_all("held_my", 6'b010100, 8'h02, 1'b1);
        bus.country_req = 1'b0;
        go(23);
        bus.country_req = 1'b1;
        go(24);
        bus.country_req = 1'b0;
        chk_all("cg_entry", 6'b100001, 8'h04, 1'b1);
        go(64); chk_all("dropped_mg0", 6'b001100, 8'h00, 1'b0);
        go(68); chk_all("dropped_hold", 6'b001100, 8'h00, 1'b0);
        bus.country_req = 1'b1;
        go(69);
        bus.country_req = 1'b0;
        go(72); chk_all("late_my", 6'b010100, 8'h02, 1'b1);
        go(80); chk_all("cg2", 6'b100001, 8'h04, 1'b1);
        go(82);
        bus.country_req = 1'b1;
        go(83);
        bus.country_req = 1'b0;
        go(104); chk_all("mg2", 6'b001100, 8'h03, 1'b1);
        go(116); chk_all("mg2_min", 6'b001100, 8'h00, 1'b0);
        go(120); chk_all("cg_req_kept", 6'b010100, 8'h02, 1'b1);

        // 4: request coincident with the deciding tick (unlatched path)
        do_reset();
        go(15); chk_all("coinc_pre", 6'b001100, 8'h00, 1'b0);
        bus.country_req = 1'b1;
        go(16);
        bus.country_req = 1'b0;
        chk_all("coinc_my", 6'b010100, 8'h02, 1'b1);

        // 5: reset pulse mid country green, latch and divider restart
        go(24); chk_all("r5_cg", 6'b100001, 8'h04, 1'b1);
        go(26);
        bus.country_req = 1'b1;
        go(27);
        bus.country_req = 1'b0;
        go(28); chk_all("r5_cg3", 6'b100001, 8'h03, 1'b0);
        go(29);
        rst = 1'b1;
        go(30);
        rst = 1'b0;
        chk_all("mid_rst", 6'b001100, 8'h03, 1'b0);
        go(33); chk_all("rst_no_tick", 6'b001100, 8'h03, 1'b0);
        go(34); chk_all("rst_tick", 6'b001100, 8'h02, 1'b0);
        go(46); chk_all("rst_req_clr", 6'b001100, 8'h00, 1'b0);

`ifdef NIGHT_FLASH_EN
        // 6: night flashing entry, blinking and exit
        do_reset();
        go(24); chk_all("n_cg", 6'b100001, 8'h04, 1'b1);
        go(25);
        bus.night = 1'b1;
        go(26); chk_all("flash_in", 6'b010010, 8'h00, 1'b1);
        go(27); chk_all("flash_hold", 6'b010010, 8'h00, 1'b0);
        go(28); chk_all("flash_off", 6'b000000, 8'h00, 1'b0);
        go(32); chk_all("flash_on", 6'b010010, 8'h00, 1'b0);
        go(33);
        bus.night = 1'b0;
        go(34); chk_all("flash_out", 6'b001100, 8'h03, 1'b1);
        go(35); chk_all("flash_out_pd", 6'b001100, 8'h03, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
